// File: rtl/bpred_pkg.sv
// Shared constants, saturating-counter helpers and the entry layout for the branch predictor.
package bpred_pkg;

  localparam int unsigned BP_MAX_CNT_W = 16;
  localparam int unsigned BP_CNT_W     = 2;
  localparam int unsigned BP_ADDR_W    = 32;
  localparam int unsigned BP_TAG_W     = 8;

  typedef logic [BP_MAX_CNT_W-1:0] ctr_ext_t;

  // Counters are passed zero-extended to BP_MAX_CNT_W so one helper serves any CNT_W.
  function automatic ctr_ext_t CTR_WT(input int unsigned cnt_w);
    return ctr_ext_t'(32'd1 << (cnt_w - 1));
  endfunction

  function automatic ctr_ext_t CTR_WNT(input int unsigned cnt_w);
    return CTR_WT(cnt_w) - ctr_ext_t'(1);
  endfunction

  function automatic ctr_ext_t sat_inc(input ctr_ext_t c, input int unsigned cnt_w);
    ctr_ext_t top_v;
    top_v = ctr_ext_t'((32'd1 << cnt_w) - 32'd1);
    return (c >= top_v) ? top_v : c + ctr_ext_t'(1);
  endfunction

  function automatic ctr_ext_t sat_dec(input ctr_ext_t c);
    return (c == '0) ? '0 : c - ctr_ext_t'(1);
  endfunction

  // Entry layout of the default configuration.
  typedef struct packed {
    logic                 valid;
    logic [BP_CNT_W-1:0]  ctr;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_TAG_W-1:0]  tag;
  } bpred_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, training and statistics signals between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] if_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [31:0]       branch_cnt_o;
  logic [31:0]       mispred_cnt_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pred_taken_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pred_taken_i,
    output pred_hit_o, pred_taken_o, pred_target_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/bpred_stats.sv
// Saturating 32-bit counters of resolved branches and mispredicted branches.
module bpred_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        mispred_i,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  logic [31:0] cnt_q [2];
  logic        inc    [2];

  assign inc[0] = en_i;
  assign inc[1] = en_i & mispred_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q[gi] <= '0;
      end else if (inc[gi] && (cnt_q[gi] != '1)) begin
        cnt_q[gi] <= cnt_q[gi] + 32'd1;
      end
    end
  end

  assign branch_cnt_o  = cnt_q[0];
  assign mispred_cnt_o = cnt_q[1];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational lookup, trained from resolved branches.
// Define BPRED_TAG_EN to store per-entry tags so aliasing PCs re-allocate instead of sharing.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [CNT_W-1:0]  ctr;
    logic [ADDR_W-1:0] target;
`ifdef BPRED_TAG_EN
    logic [TAG_W-1:0]  tag;
`endif
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d;
  entry_t           lk_e;
  entry_t           upd_e;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             lk_hit;
  logic             upd_hit;
  logic             upd_en;
  logic             unused_pc;

  assign lk_idx  = bp.if_pc_i[IDX_W+1:2];
  assign upd_idx = bp.upd_pc_i[IDX_W+1:2];
  assign lk_e    = entry_q[lk_idx];
  assign upd_e   = entry_q[upd_idx];
  assign upd_en  = start_i & bp.upd_valid_i;
  // Only the index (and tag) bits of the update PC select an entry.
  assign unused_pc = ^bp.upd_pc_i;

`ifdef BPRED_TAG_EN
  assign lk_hit  = lk_e.valid  && (lk_e.tag  == bp.if_pc_i[IDX_W+TAG_W+1:IDX_W+2]);
  assign upd_hit = upd_e.valid && (upd_e.tag == bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2]);
`else
  assign lk_hit  = lk_e.valid;
  assign upd_hit = upd_e.valid;
`endif

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  always_comb begin
    bp.pred_hit_o    = lk_hit;
    bp.pred_taken_o  = start_i & lk_hit & lk_e.ctr[CNT_W-1];
    bp.pred_target_o = bp.pred_taken_o ? lk_e.target : bp.if_pc_i + ADDR_W'(4);
  end

  always_comb begin
    entry_d = upd_e;
    if (upd_hit) begin
      if (bp.upd_taken_i) begin
        entry_d.ctr    = CNT_W'(sat_inc(ctr_ext_t'(upd_e.ctr), CNT_W));
        entry_d.target = bp.upd_target_i;
      end else begin
        entry_d.ctr    = CNT_W'(sat_dec(ctr_ext_t'(upd_e.ctr)));
      end
    end else begin
      entry_d.valid  = 1'b1;
      entry_d.ctr    = bp.upd_taken_i ? CNT_W'(CTR_WT(CNT_W)) : CNT_W'(CTR_WNT(CNT_W));
      entry_d.target = bp.upd_target_i;
`ifdef BPRED_TAG_EN
      entry_d.tag    = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
`endif
    end
  end

  // Table lives in flops so reset can clear every entry in a single cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        entry_q[gi] <= '0;
      end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
        entry_q[gi] <= entry_d;
      end
    end
  end

  bpred_stats u_stats (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (upd_en),
    .mispred_i     (bp.upd_pred_taken_i != bp.upd_taken_i),
    .branch_cnt_o  (bp.branch_cnt_o),
    .mispred_cnt_o (bp.mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (DEPTH=64, CNT_W=2) with hand-computed expectations.
module tb_branch_predictor;

  logic clk_i = 1'b0;
  logic rst_i;
  logic start_i;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_bc   = 0;
  int   exp_mc   = 0;

  branch_predictor_if #(.ADDR_W(32)) bp_if ();

  branch_predictor #(.DEPTH(64), .CNT_W(2), .ADDR_W(32), .TAG_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .bp      (bp_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic taken, input logic [31:0] tgt);
    bp_if.if_pc_i = pc;
    #1;
    $display("LOOK %s pc=0x%0h hit=%0b taken=%0b target=0x%0h", tag, pc,
             bp_if.pred_hit_o, bp_if.pred_taken_o, bp_if.pred_target_o);
    check({tag, ".hit"},    32'(bp_if.pred_hit_o),   32'(hit));
    check({tag, ".taken"},  32'(bp_if.pred_taken_o), 32'(taken));
    check({tag, ".target"}, bp_if.pred_target_o,     tgt);
  endtask

  task automatic stats(input string tag);
    check({tag, ".branch_cnt"},  bp_if.branch_cnt_o,  32'(exp_bc));
    check({tag, ".mispred_cnt"}, bp_if.mispred_cnt_o, 32'(exp_mc));
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic pred);
    bp_if.upd_valid_i      = 1'b1;
    bp_if.upd_pc_i         = pc;
    bp_if.upd_taken_i      = taken;
    bp_if.upd_target_i     = tgt;
    bp_if.upd_pred_taken_i = pred;
    $display("UPD pc=0x%0h taken=%0b target=0x%0h pred=%0b start=%0b rst=%0b",
             pc, taken, tgt, pred, start_i, rst_i);
    tick();
    bp_if.upd_valid_i = 1'b0;
    if (start_i && !rst_i) begin
      exp_bc++;
      if (pred != taken) exp_mc++;
    end
  endtask

  task automatic reset_cycle(input logic with_upd);
    rst_i = 1'b1;
    if (with_upd) upd(32'h300, 1'b1, 32'h40, 1'b0);
    else tick();
    rst_i  = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
  endtask

  initial begin
    rst_i                  = 1'b0;
    start_i                = 1'b1;
    bp_if.if_pc_i          = 32'h0;
    bp_if.upd_valid_i      = 1'b0;
    bp_if.upd_pc_i         = 32'h0;
    bp_if.upd_taken_i      = 1'b0;
    bp_if.upd_target_i     = 32'h0;
    bp_if.upd_pred_taken_i = 1'b0;
    reset_cycle(1'b0);

    // 1: reset state
    look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    stats("rst");
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // 2: counter training on 0x100 (idx 0)
    upd(32'h100, 1'b1, 32'h80, 1'b0);           // alloc -> ctr 2
    look("alloc_t", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'hDEAD, 1'b1);         // ctr 1
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'hDEAD, 1'b0);         // ctr 0
    upd(32'h100, 1'b0, 32'hDEAD, 1'b0);         // stays 0
    look("nt_sat", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0);           // ctr 1
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0);           // ctr 2
    upd(32'h100, 1'b1, 32'h80, 1'b1);           // ctr 3
    upd(32'h100, 1'b1, 32'h80, 1'b1);           // stays 3
    upd(32'h100, 1'b0, 32'hDEAD, 1'b1);         // ctr 2, target kept
    look("t_sat", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'hDEAD, 1'b1);         // ctr 1
    look("t_dec", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h90, 1'b0);           // ctr 2, new target
    look("retarget", 32'h100, 1'b1, 1'b1, 32'h90);
    stats("train");

    // alloc not-taken at idx 3, then taken
    upd(32'h10C, 1'b0, 32'h500, 1'b0);
    look("alloc_nt", 32'h10C, 1'b1, 1'b0, 32'h110);
    upd(32'h10C, 1'b1, 32'h600, 1'b0);
    look("alloc_nt_t", 32'h10C, 1'b1, 1'b1, 32'h600);

    // 3: aliasing PC 0x200 shares idx 0
`ifdef BPRED_TAG_EN
    look("alias", 32'h200, 1'b0, 1'b0, 32'h204);
`else
    look("alias", 32'h200, 1'b1, 1'b1, 32'h90);
`endif

    // 4: same-cycle update and lookup, no bypass (ctr 2 -> 1)
    bp_if.if_pc_i          = 32'h100;
    bp_if.upd_valid_i      = 1'b1;
    bp_if.upd_pc_i         = 32'h100;
    bp_if.upd_taken_i      = 1'b0;
    bp_if.upd_target_i     = 32'h0;
    bp_if.upd_pred_taken_i = 1'b1;
    #1;
    check("same_cycle.taken", 32'(bp_if.pred_taken_o), 32'd1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("after_same", 32'h100, 1'b1, 1'b0, 32'h104);

    // 5: statistics, and reset with a pending update
    reset_cycle(1'b1);
    stats("rst2");
    look("rst2_300", 32'h300, 1'b0, 1'b0, 32'h304);
    upd(32'h204, 1'b1, 32'h20, 1'b1);
    upd(32'h204, 1'b1, 32'h20, 1'b0);
    upd(32'h204, 1'b0, 32'h20, 1'b0);
    check("stats3.branch_cnt",  bp_if.branch_cnt_o,  32'd3);
    check("stats3.mispred_cnt", bp_if.mispred_cnt_o, 32'd1);
    look("pre_rst3", 32'h204, 1'b1, 1'b1, 32'h20);
    reset_cycle(1'b1);
    stats("rst3");
    look("rst3_204", 32'h204, 1'b0, 1'b0, 32'h208);
    look("rst3_300", 32'h300, 1'b0, 1'b0, 32'h304);

    // 6: start_i low gates predictions and training
    upd(32'h100, 1'b1, 32'h80, 1'b0);           // ctr 2
    upd(32'h100, 1'b1, 32'h80, 1'b1);           // ctr 3
    upd(32'h100, 1'b0, 32'h0, 1'b1);            // ctr 2
    start_i = 1'b0;
    look("stop", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    upd(32'h208, 1'b1, 32'h70, 1'b0);
    stats("stop");
    start_i = 1'b1;
    look("resume_100", 32'h100, 1'b1, 1'b1, 32'h80);
    look("resume_208", 32'h208, 1'b0, 1'b0, 32'h20C);
    check("resume.branch_cnt", bp_if.branch_cnt_o, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU. It replaces the fixed predict-not-taken scheme, in which every taken branch resolved in ID costs a flush. The IF stage looks up the current PC combinationally and gets a predicted next PC. The ID stage feeds resolved branch outcomes back to train a direct-mapped table of saturating counters and targets. Built-in statistics counters report the branch count and the mispredict count.

## Interface
- `DEPTH`, 64: table entries; power of 2, at least 2. `IDX_W = log2(DEPTH)`.
- `CNT_W`, 2: saturating counter width, at least 1.
- `ADDR_W`, 32: PC width.
- `TAG_W`, 8: tag width; used only with `BPRED_TAG_EN`.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  CPU run enable. When low: no predictions and no updates.
- `if_pc_i`  in  ADDR_W  PC being fetched.
- `pred_hit_o`  out  1  valid (and, with tags, tag-matching) entry at the lookup index.
- `pred_taken_o`  out  1  predicted taken.
- `pred_target_o`  out  ADDR_W  predicted next PC.
- `upd_valid_i`  in  1  a resolved branch is presented this cycle.
- `upd_pc_i`  in  ADDR_W  PC of the resolved branch.
- `upd_taken_i`  in  1  actual outcome.
- `upd_target_i`  in  ADDR_W  actual taken target.
- `upd_pred_taken_i`  in  1  prediction made for this branch, carried down the pipeline.
- `branch_cnt_o`  out  32  resolved branches counted.
- `mispred_cnt_o`  out  32  mispredicted branches counted.

## Operation
- Index = `pc[IDX_W+1:2]`. Tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Each entry holds: a valid bit, a counter `ctr[CNT_W]`, a target `[ADDR_W]` and, with tags, a tag.
- Lookup is combinational from the registered table.
  - `pred_hit_o` = `valid[idx]`, ANDed with a tag match when tags are enabled.
  - `pred_taken_o` = `start_i & pred_hit_o & ctr[idx][CNT_W-1]`.
  - `pred_target_o` = `pred_taken_o ? target[idx] : if_pc_i + 4`, truncated to ADDR_W (wraps).
- Training happens on a clock edge when `upd_valid_i & start_i`:
  - **Hit:** taken increments `ctr`, saturating at `2^CNT_W-1`; not-taken decrements, saturating at 0. On taken, `target` is overwritten with `upd_target_i`.
  - **Miss (allocate):** set valid, write tag and `target = upd_target_i`. Set `ctr = 2^(CNT_W-1)` if taken (weakly taken), else `2^(CNT_W-1)-1` (weakly not-taken).
- Statistics, on `upd_valid_i & start_i`:
  - `branch_cnt_o` increments.
  - `mispred_cnt_o` increments when `upd_pred_taken_i != upd_taken_i`.
  - Both counters saturate at `2^32-1`; they never wrap.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents. The update is visible on the next cycle. No bypass.

## Timing
- Reset takes effect on the edge where `rst_i` = 1:
  - all valid bits cleared, all `ctr` = 0, targets and tags = 0, both statistics counters = 0;
  - an update presented in a reset cycle is discarded.
- Output values after reset: `pred_hit_o`=0, `pred_taken_o`=0, `pred_target_o`=`if_pc_i+4`, `branch_cnt_o`=0, `mispred_cnt_o`=0.
- Reset asserted mid-run clears all state in one cycle; there is no multi-cycle init sequence.
- Lookup latency: 0 cycles (comb).
- Update-to-visible latency: 1 cycle.
- One update per cycle maximum.
- `upd_*` fields other than `upd_valid_i` are don't-care when `upd_valid_i`=0.

## Configuration
- `BPRED_TAG_EN`
  - **Defined:** per-entry `TAG_W` tag stored. A lookup hits only on valid plus tag match. An update on a tag mismatch re-allocates the entry (replaces it).
  - **Undefined:** no tag storage; hit = valid only. Aliasing PCs share an entry and are trained in place.

## Structure
- Package `bpred_pkg`:
  - counter init constants (`CTR_WNT`, `CTR_WT` as functions of `CNT_W`);
  - `sat_inc`/`sat_dec` functions;
  - an entry struct typedef.
- Sub-module `bpred_stats`: the two saturating 32-bit statistics counters with their reset and enable logic.
- Table storage is flops, so it can be cleared in one cycle; it is not inferred RAM.

## Test plan
All scenarios use `DEPTH`=64, `CNT_W`=2.
1. Reset, `start_i`=1, lookup `0x100` -> hit 0, taken 0, target `0x104`; both statistics counters 0.
2. Update `0x100` taken, target `0x80` -> next cycle, lookup `0x100` gives hit 1, taken 1, target `0x80`, ctr 2. Two not-taken updates -> ctr 0 and taken 0; a third not-taken leaves ctr 0. Four taken updates -> ctr 3.
3. Tags: allocate `0x100` (taken), then look up `0x200` (same index 0).
   - With `BPRED_TAG_EN`: hit 0, target `0x204`.
   - Without `BPRED_TAG_EN`: hit 1, target `0x80`.
4. Same cycle: update `0x100` not-taken from ctr 2 while looking up `0x100` -> lookup still shows taken; the next cycle shows not-taken.
5. Three updates with `upd_pred_taken_i`/`upd_taken_i` pairs (1,1), (0,1), (0,0) -> `branch_cnt_o`=3, `mispred_cnt_o`=1. Then `rst_i` for one cycle with `upd_valid_i`=1 -> both 0 and the table cleared.
6. `start_i`=0 with an entry trained taken -> `pred_taken_o`=0, and updates are ignored (counters and table unchanged).
